// File: rtl/ext_pkg.sv
// Shared extension-mode encodings and error-counter constants for the
// immediate-extension pipeline.
package ext_pkg;

    typedef enum logic [2:0] {
        EXT_SIGN     = 3'b000,
        EXT_ZERO     = 3'b001,
        EXT_UPPER    = 3'b010,
        EXT_SIGN_SL2 = 3'b011,
        EXT_BSIGN    = 3'b100,
        EXT_BZERO    = 3'b101,
        EXT_RSV6     = 3'b110,
        EXT_RSV7     = 3'b111
    } ext_op_e;

    localparam int unsigned           ERR_CNT_W   = 8;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

    function automatic logic is_reserved(input logic [2:0] op);
        return (op == EXT_RSV6) || (op == EXT_RSV7);
    endfunction

endpackage

// File: rtl/ext_core.sv
// Purely combinational immediate extender: selects one of six extension
// modes and flags the two reserved encodings.
module ext_core
    import ext_pkg::*;
#(
    parameter int IMM_W  = 16,
    parameter int DATA_W = 32
) (
    input  logic [IMM_W-1:0]  imm_i,
    input  logic [2:0]        eop_i,
    output logic [DATA_W-1:0] value_o,
    output logic              err_o
);

    localparam int PAD_W = DATA_W - IMM_W;

    logic [DATA_W-1:0] sext;
    logic [DATA_W-1:0] zext;
    logic [DATA_W-1:0] uext;
    logic [DATA_W-1:0] sl2ext;
    logic [DATA_W-1:0] bsext;
    logic [DATA_W-1:0] bzext;

    assign sext   = {{PAD_W{imm_i[IMM_W-1]}}, imm_i};
    assign zext   = {{PAD_W{1'b0}}, imm_i};
    assign uext   = {imm_i, {PAD_W{1'b0}}};
    // Shifting the sign extension drops its two top bits, which are copies
    // of the sign anyway since DATA_W exceeds IMM_W+1.
    assign sl2ext = {sext[DATA_W-3:0], 2'b00};
    assign bsext  = {{(DATA_W-8){imm_i[7]}}, imm_i[7:0]};
    assign bzext  = {{(DATA_W-8){1'b0}}, imm_i[7:0]};

    always_comb begin
        value_o = '0;
        err_o   = 1'b0;
        case (ext_op_e'(eop_i))
            EXT_SIGN:     value_o = sext;
            EXT_ZERO:     value_o = zext;
            EXT_UPPER:    value_o = uext;
            EXT_SIGN_SL2: value_o = sl2ext;
            EXT_BSIGN:    value_o = bsext;
            EXT_BZERO:    value_o = bzext;
            default:      err_o   = is_reserved(eop_i);
        endcase
    end

endmodule

// File: rtl/ext_pipe.sv
// Immediate-extension pipeline: one combinational extender feeding a small
// circular output buffer, plus a saturating count of reserved-mode inputs.
module ext_pipe
    import ext_pkg::*;
#(
    parameter int IMM_W  = 16,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IMM_W-1:0]     imm,
    input  logic [2:0]           EOp,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    ext,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [DATA_W-1:0]    core_value;
    logic                 core_err;

    logic [DATA_W-1:0]    val_mem_q [DEPTH];
    logic                 err_mem_q [DEPTH];

    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic                 push;
    logic                 pop;

    ext_core #(
        .IMM_W  (IMM_W),
        .DATA_W (DATA_W)
    ) u_core (
        .imm_i   (imm),
        .eop_i   (EOp),
        .value_o (core_value),
        .err_o   (core_err)
    );

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // Handshake: a beat moves on either side only on a rising edge where
    // valid and ready are both high. in_ready depends on stored state only
    // (count below DEPTH), so a full buffer refuses input even while the
    // consumer pops in that same cycle. out_valid/ext/err come straight from
    // the head entry and cannot change until it is popped, flushed or reset.
    assign in_ready  = (count_q < CNT_FULL);
    assign out_valid = (count_q != '0);
    assign ext       = out_valid ? val_mem_q[rd_ptr_q] : '0;
    assign err       = out_valid & err_mem_q[rd_ptr_q];
    assign err_cnt   = err_cnt_q;

    // Flush takes priority over any push, so a flushed beat is neither
    // stored nor counted as an error.
    assign push = in_valid & in_ready & ~flush;
    assign pop  = out_valid & out_ready;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        err_cnt_d = err_cnt_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end

        if (push && core_err && (err_cnt_q != ERR_CNT_MAX)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            err_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Storage needs no reset: an entry is only visible once count covers it.
    always_ff @(posedge clk) begin
        if (push && reset) begin
            val_mem_q[wr_ptr_q] <= core_value;
            err_mem_q[wr_ptr_q] <= core_err;
        end
    end

endmodule

// File: tb/tb_ext_pipe.sv
// Self-checking bench for ext_pipe: scenario tasks with a scoreboard queue of
// {err, ext} results pushed at acceptance and compared at each pop.
module tb_ext_pipe;

    localparam int IMM_W  = 16;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              out_ready = 1'b0;
    logic [IMM_W-1:0]  imm = '0;
    logic [2:0]        eop = '0;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] ext;
    logic              err;
    logic [7:0]        err_cnt;

    logic [DATA_W:0]   exp_q[$];
    int                checks = 0;
    int                errors = 0;
    int                m_err_cnt = 0;

    ext_pipe #(
        .IMM_W  (IMM_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .imm       (imm),
        .EOp       (eop),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ext       (ext),
        .err       (err),
        .err_cnt   (err_cnt)
    );

    // Clock / reset
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not reach its summary");
        $fatal(1, "timeout");
    end

    function automatic logic [DATA_W:0] model(input logic [15:0] d, input logic [2:0] op);
        logic signed [31:0] s16;
        logic signed [31:0] s8;
        s16 = 32'($signed(d));
        s8  = 32'($signed(d[7:0]));
        case (op)
            3'd0:    model = {1'b0, s16};
            3'd1:    model = {17'h0, d};
            3'd2:    model = {1'b0, d, 16'h0};
            3'd3:    model = {1'b0, s16 * 32'sd4};
            3'd4:    model = {1'b0, s8};
            3'd5:    model = {25'h0, d[7:0]};
            default: model = {1'b1, 32'h0};
        endcase
    endfunction

    // Driver: applies inputs for the coming edge and records accepted beats.
    task automatic drive(input logic v, input logic [15:0] d, input logic [2:0] op,
                         input logic ordy);
        in_valid  = v;
        imm       = d;
        eop       = op;
        out_ready = ordy;
        if (v && reset && !flush && exp_q.size() < DEPTH) begin
            exp_q.push_back(model(d, op));
            if (op[2:1] == 2'b11 && m_err_cnt < 255) m_err_cnt++;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        drive(1'b1, 16'h1234, 3'b000, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b0;
        exp_q.delete();
        m_err_cnt = 0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
        checks++; if (ext !== 32'h0) begin errors++; $display("FAIL reset_ext: got %h expected 0", ext); end
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err_cnt: got %0d expected 0", err_cnt); end
    endtask

    task automatic test_sign();
        logic [DATA_W:0] e;
        @(negedge clk); drive(1'b1, 16'h8001, 3'b000, 1'b1);
        @(negedge clk); drive(1'b0, 16'h0, 3'b000, 1'b1);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sign_latency: out_valid=%b expected 1", out_valid); end
        checks++; if (ext !== 32'hFFFF8001) begin errors++; $display("FAIL sign_ext: got %h expected ffff8001", ext); end
        if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin errors++; $display("FAIL sign_pop: unexpected entry ext=%h", ext); end
            else begin
                e = exp_q.pop_front();
                if ({err, ext} !== e) begin errors++; $display("FAIL sign_pop: got err=%b ext=%h expected err=%b ext=%h", err, ext, e[DATA_W], e[DATA_W-1:0]); end
            end
        end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || ext !== 32'h0) begin errors++; $display("FAIL sign_empty: out_valid=%b ext=%h expected 0/0", out_valid, ext); end
    endtask

    task automatic test_sweep();
        logic [2:0]        ops [5] = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b101};
        logic [DATA_W-1:0] tbl [5] = '{32'h0000FFFF, 32'hFFFF0000, 32'hFFFFFFFC, 32'hFFFFFFFF, 32'h000000FF};
        logic [DATA_W:0]   e;
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            if (k < 5) drive(1'b1, 16'hFFFF, ops[k], 1'b1);
            else       drive(1'b0, 16'h0, 3'b000, 1'b1);
            if (k > 0) begin
                checks++;
                if (out_valid !== 1'b1 || ext !== tbl[k-1] || err !== 1'b0) begin
                    errors++; $display("FAIL sweep_op%0d: out_valid=%b err=%b ext=%h expected 1/0/%h", k, out_valid, err, ext, tbl[k-1]);
                end
                if (out_valid && out_ready && exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    checks++; if ({err, ext} !== e) begin errors++; $display("FAIL sweep_pop: got %h expected %h", {err, ext}, e); end
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [DATA_W:0] e;
        @(negedge clk); drive(1'b1, 16'h0123, 3'b001, 1'b0);
        @(negedge clk);
        checks++; if (in_ready !== 1'b1 || ext !== 32'h00000123) begin errors++; $display("FAIL bp_first: in_ready=%b ext=%h expected 1/00000123", in_ready, ext); end
        drive(1'b1, 16'h8456, 3'b000, 1'b0);
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full: in_ready=%b expected 0", in_ready); end
        drive(1'b1, 16'h0789, 3'b001, 1'b0);
        @(negedge clk);
        checks++; if (in_ready !== 1'b0 || ext !== 32'h00000123) begin errors++; $display("FAIL bp_hold: in_ready=%b ext=%h expected 0/00000123", in_ready, ext); end
        for (int i = 0; i < 2; i++) begin
            if (i > 0) @(negedge clk);
            drive(1'b0, 16'h0, 3'b000, 1'b1);
            checks++;
            if (!out_valid || exp_q.size() == 0) begin errors++; $display("FAIL bp_pop%0d: out_valid=%b with %0d expected entries", i, out_valid, exp_q.size()); end
            else begin
                e = exp_q.pop_front();
                if ({err, ext} !== e) begin errors++; $display("FAIL bp_pop%0d: got %h expected %h", i, {err, ext}, e); end
            end
        end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_third_dropped: out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready); end
    endtask

    task automatic test_back_to_back();
        logic [DATA_W:0] e;
        @(negedge clk); drive(1'b1, 16'h1000, 3'b000, 1'b0);
        for (int i = 1; i <= 11; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b1) begin errors++; $display("FAIL b2b_count%0d: out_valid=%b in_ready=%b expected 1/1", i, out_valid, in_ready); end
            if (i <= 10) drive(1'b1, 16'(i * 16'h1357), 3'($urandom_range(0, 5)), 1'b1);
            else         drive(1'b0, 16'h0, 3'b000, 1'b1);
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL b2b_pop%0d: unexpected entry %h", i, ext); end
                else begin
                    e = exp_q.pop_front();
                    if ({err, ext} !== e) begin errors++; $display("FAIL b2b_pop%0d: got %h expected %h", i, {err, ext}, e); end
                end
            end
        end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained: out_valid=%b expected 0", out_valid); end
    endtask

    task automatic test_random();
        logic [DATA_W:0] e;
        logic [DATA_W:0] hold_val;
        logic            hold = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (hold) begin
                checks++;
                if (out_valid !== 1'b1 || {err, ext} !== hold_val) begin errors++; $display("FAIL rand_stable%0d: got %b/%h expected held %h", i, out_valid, {err, ext}, hold_val); end
            end
            checks++;
            if (out_valid !== (exp_q.size() != 0) || in_ready !== (exp_q.size() < DEPTH)) begin
                errors++; $display("FAIL rand_flags%0d: out_valid=%b in_ready=%b with %0d expected entries", i, out_valid, in_ready, exp_q.size());
            end
            if (i < 90) drive(1'($urandom_range(0, 3) != 0), 16'($urandom_range(0, 65535)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 2) != 0));
            else        drive(1'b0, 16'h0, 3'b000, 1'b1);
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL rand_pop%0d: unexpected entry %h", i, ext); end
                else begin
                    e = exp_q.pop_front();
                    if ({err, ext} !== e) begin errors++; $display("FAIL rand_pop%0d: got %h expected %h", i, {err, ext}, e); end
                end
            end
            hold = out_valid && !out_ready;
            hold_val = {err, ext};
        end
        checks++; if (err_cnt !== 8'(m_err_cnt)) begin errors++; $display("FAIL rand_err_cnt: got %0d expected %0d", err_cnt, m_err_cnt); end
    endtask

    task automatic test_flush_reset();
        for (int r = 0; r < 3; r++) begin
            @(negedge clk); drive(1'b1, 16'($urandom_range(0, 65535)), 3'b001, 1'b0);
            if (r != 2) begin @(negedge clk); drive(1'b1, 16'($urandom_range(0, 65535)), 3'b111, 1'b0); end
            @(negedge clk);
            if (r == 1) reset = 1'b0; else flush = 1'b1;
            drive(1'b1, 16'hABCD, 3'b000, 1'b1);
            exp_q.delete();
            if (r == 1) m_err_cnt = 0;
            @(negedge clk);
            reset = 1'b1;
            flush = 1'b0;
            drive(1'b0, 16'h0, 3'b000, 1'b0);
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || ext !== 32'h0) begin
                errors++; $display("FAIL clear_run%0d: out_valid=%b in_ready=%b ext=%h expected 0/1/0", r, out_valid, in_ready, ext);
            end
            checks++; if (err_cnt !== 8'(m_err_cnt)) begin errors++; $display("FAIL clear_err_cnt%0d: got %0d expected %0d", r, err_cnt, m_err_cnt); end
        end
    endtask

    task automatic test_err_sat();
        logic [DATA_W:0] e;
        apply_reset();
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (n % 50 == 0) begin
                checks++; if (err_cnt !== 8'(m_err_cnt)) begin errors++; $display("FAIL sat_cnt%0d: got %0d expected %0d", n, err_cnt, m_err_cnt); end
            end
            drive(1'b1, 16'($urandom_range(0, 65535)), 3'b111, 1'b1);
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL sat_pop%0d: unexpected entry %h", n, ext); end
                else begin
                    e = exp_q.pop_front();
                    if ({err, ext} !== e || err !== 1'b1 || ext !== 32'h0) begin errors++; $display("FAIL sat_pop%0d: got err=%b ext=%h expected 1/0", n, err, ext); end
                end
            end
        end
        @(negedge clk); drive(1'b1, 16'h5555, 3'b111, 1'b0);
        @(negedge clk);
        checks++; if (err_cnt !== 8'd255) begin errors++; $display("FAIL sat_255: got %0d expected 255", err_cnt); end
        flush = 1'b1;
        drive(1'b1, 16'h0, 3'b000, 1'b1);
        exp_q.delete();
        @(negedge clk);
        flush = 1'b0;
        drive(1'b1, 16'h7FFF, 3'b011, 1'b1);
        checks++; if (err_cnt !== 8'd255 || out_valid !== 1'b0) begin errors++; $display("FAIL sat_flush: err_cnt=%0d out_valid=%b expected 255/0", err_cnt, out_valid); end
        @(negedge clk);
        drive(1'b0, 16'h0, 3'b000, 1'b1);
        checks++; if (out_valid !== 1'b1 || ext !== 32'h0001FFFC) begin errors++; $display("FAIL post_flush_push: out_valid=%b ext=%h expected 1/0001fffc", out_valid, ext); end
        if (exp_q.size() != 0) e = exp_q.pop_front();
    endtask

    initial begin
        test_reset();
        test_sign();
        test_sweep();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_flush_reset();
        test_err_sat();
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ext_pipe.md
EXT_PIPE -- requirements
Module: ext_pipe

Interface
REQ-001 The block SHALL have parameter IMM_W, default 16, meaning immediate input width (legal 9..DATA_W-2).
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning extended output width (legal > IMM_W+1).
REQ-003 The block SHALL have parameter DEPTH, default 2, meaning output buffer entries (legal 2..8).
REQ-004 The block SHALL have port clk, input, 1, meaning the single clock, with all state updating on its rising edge.
REQ-005 The block SHALL have port reset, input, 1, meaning the synchronous, active-low reset (0 = reset, sampled on rising clk).
REQ-006 The block SHALL have port flush, input, 1, meaning discard all buffered entries.
REQ-007 The block SHALL have port in_valid, input, 1, meaning imm/EOp are presented.
REQ-008 The block SHALL have port in_ready, output, 1, meaning the block accepts input this cycle.
REQ-009 The block SHALL have port imm, input, IMM_W, meaning the raw immediate.
REQ-010 The block SHALL have port EOp, input, 3, meaning the extension mode.
REQ-011 The block SHALL have port out_valid, output, 1, meaning the head entry is valid.
REQ-012 The block SHALL have port out_ready, input, 1, meaning the consumer takes the head entry.
REQ-013 The block SHALL have port ext, output, DATA_W, meaning the head entry's extended value.
REQ-014 The block SHALL have port err, output, 1, meaning the head entry used a reserved EOp.
REQ-015 The block SHALL have port err_cnt, output, 8, meaning the saturating count of accepted reserved-EOp inputs.

Function
REQ-016 EOp 000 SHALL produce the sign extension of imm to DATA_W.
REQ-017 EOp 001 SHALL produce the zero extension of imm.
REQ-018 EOp 010 SHALL produce imm placed in bits [DATA_W-1:DATA_W-IMM_W], with lower bits 0.
REQ-019 EOp 011 SHALL produce the sign extension shifted left by 2, with the top bits truncated to DATA_W.
REQ-020 EOp 100 SHALL produce the sign extension of imm[7:0]; EOp 101 SHALL produce the zero extension of imm[7:0].
REQ-021 EOp 110/111 SHALL be reserved: the entry stores ext=0 and err=1; every other EOp stores err=0.
REQ-022 A transfer SHALL occur when in_valid&in_ready; the computed result SHALL be written to the buffer tail on that edge.
REQ-023 in_ready SHALL equal (count<DEPTH) and SHALL be independent of out_ready, with no combinational path from out_ready.
REQ-024 Latency SHALL be 1 cycle: an entry accepted into an empty buffer SHALL appear on out_valid/ext/err on the next cycle.
REQ-025 A pop SHALL occur when out_valid&out_ready; entries SHALL leave in acceptance order (FIFO).
REQ-026 ext/err SHALL hold stable while out_valid=1 and out_ready=0.
REQ-027 A simultaneous push and pop SHALL leave count unchanged and preserve order, including when count=DEPTH-1.
REQ-028 When count=DEPTH, in_ready=0 and input SHALL be ignored even if a pop occurs in the same cycle.
REQ-029 Read and write pointers SHALL wrap from DEPTH-1 to 0.
REQ-030 flush=1 SHALL set count and both pointers to 0 on the next edge, overriding any same-cycle push and pop.
REQ-031 err_cnt SHALL increment on each accepted reserved-EOp input, saturate at 255, and SHALL NOT be cleared by flush.

Reset
REQ-032 While reset=0 at a clock edge, count, pointers and err_cnt SHALL become 0, so that out_valid=0, in_ready=1 and err=0.
REQ-033 While out_valid=0, ext SHALL read 0.
REQ-034 Reset asserted mid-stream SHALL discard all entries, and no push SHALL be taken in the reset cycle.

Structure
REQ-035 The EOp encodings (EXT_SIGN, EXT_ZERO, EXT_UPPER, EXT_SIGN_SL2, EXT_BSIGN, EXT_BZERO) SHALL live in the shared package ext_pkg.
REQ-036 Mode decoding SHALL be a purely combinational sub-module ext_core (imm, EOp -> value, err), instantiated once ahead of the buffer.

Verification
REQ-037 Reset, then imm=16'h8001 with EOp=000 and out_ready=1 -> next cycle out_valid=1, ext=32'hFFFF8001.
REQ-038 Sweep imm=16'hFFFF through EOp 001/010/011/100/101 -> ext = 0000FFFF / FFFF0000 / FFFFFFFC / FFFFFFFF / 000000FF.
REQ-039 out_ready=0 with 3 pushes (DEPTH=2) -> in_ready=0 after 2 pushes, third value not stored; then out_ready=1 -> first two values pop in order.
REQ-040 Hold count=1 and push+pop continuously for 10 cycles -> count stays 1 and values pop in order across pointer wrap.
REQ-041 Push EOp=111 300 times -> each entry err=1 and ext=0, err_cnt=255; a subsequent flush leaves err_cnt=255 and out_valid=0.
REQ-042 Buffer full while flush=1, in_valid=1 and reset=0 are applied in separate runs -> next cycle out_valid=0 and in_ready=1 in each case.
